// File: rtl/shift_reg_ctrl.sv
// Command sequencer driving j/k/d for a WIDTH-bit array of ff cells.
// Optional abort support is enabled by defining SHREG_CTRL_ABORT_EN.
module shift_reg_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] ff_q,
    output logic [WIDTH-1:0] ff_j,
    output logic [WIDTH-1:0] ff_k,
    output logic [WIDTH-1:0] ff_d,
    output logic             ser_out,
    output logic             busy,
`ifdef SHREG_CTRL_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_SET  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_INV  = 3'b110;
    localparam logic [2:0] OP_ROTL = 3'b111;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] rem;

    logic accept;
    logic is_shift;
    logic zero_run;
    logic last_step;
    logic abort_hit;

    assign accept    = cmd_valid && (state == IDLE);
    assign is_shift  = (cmd_op == OP_SHL) || (cmd_op == OP_SHR)
                    || (cmd_op == OP_ROTL);
    assign zero_run  = (cmd_op == OP_NOP) || (is_shift && (cmd_cnt == '0));
    assign last_step = (rem == CNT_W'(1));

`ifdef SHREG_CTRL_ABORT_EN
    assign abort_hit = abort && (state == EXEC);
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = zero_run ? DONE : EXEC;
            EXEC:    if (last_step || abort_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-step ops load rem=1 so every op leaves EXEC on the same test.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            data_q <= '0;
            rem    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
                rem    <= is_shift ? cmd_cnt : CNT_W'(1);
            end else if (state == EXEC) begin
                rem <= abort_hit ? '0 : rem - CNT_W'(1);
            end
        end
    end

`ifdef SHREG_CTRL_ABORT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted <= 1'b0;
        end else if (accept) begin
            aborted <= 1'b0;
        end else if (abort_hit) begin
            aborted <= 1'b1;
        end
    end
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Outside EXEC the cells reload their own value.
    always_comb begin
        ff_j    = '1;
        ff_k    = '1;
        ff_d    = ff_q;
        ser_out = 1'b0;
        if (state == EXEC) begin
            unique case (op_q)
                OP_CLR:  ff_j = '0;
                OP_SET:  ff_k = '0;
                OP_INV: begin
                    ff_j = '0;
                    ff_k = '0;
                end
                OP_LOAD: ff_d = data_q;
                OP_SHL: begin
                    ff_d    = {ff_q[WIDTH-2:0], ser_in};
                    ser_out = ff_q[WIDTH-1];
                end
                OP_SHR: begin
                    ff_d    = {ser_in, ff_q[WIDTH-1:1]};
                    ser_out = ff_q[0];
                end
                OP_ROTL: begin
                    ff_d    = {ff_q[WIDTH-2:0], ff_q[WIDTH-1]};
                    ser_out = ff_q[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Directed bench for shift_reg_ctrl driving a behavioural ff-cell array.
// Define SHREG_CTRL_ABORT_EN to also exercise the abort path.
module tb_shift_reg_ctrl;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] CLR  = 3'b001;
    localparam logic [2:0] SET  = 3'b010;
    localparam logic [2:0] LOAD = 3'b011;
    localparam logic [2:0] SHL  = 3'b100;
    localparam logic [2:0] SHR  = 3'b101;
    localparam logic [2:0] INV  = 3'b110;
    localparam logic [2:0] ROTL = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic [7:0] cmd_data;
    logic       ser_in;
    logic [7:0] q = '0;
    logic [7:0] ff_j;
    logic [7:0] ff_k;
    logic [7:0] ff_d;
    logic       ser_out;
    logic       busy;
    logic       done;
`ifdef SHREG_CTRL_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int passed = 0;
    int total  = 0;
    int bcyc;
    int dcnt;

    shift_reg_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_cnt(cmd_cnt),
        .cmd_data(cmd_data),
        .ser_in(ser_in),
        .ff_q(q),
        .ff_j(ff_j),
        .ff_k(ff_k),
        .ff_d(ff_d),
        .ser_out(ser_out),
        .busy(busy),
`ifdef SHREG_CTRL_ABORT_EN
        .abort(abort),
        .aborted(aborted),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    // JK-style cells: 00 toggle, j-only set, k-only clear, 11 load d.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            case ({ff_j[i], ff_k[i]})
                2'b00:   q[i] <= ~q[i];
                2'b01:   q[i] <= 1'b0;
                2'b10:   q[i] <= 1'b1;
                default: q[i] <= ff_d[i];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] cnt,
                         input logic [7:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_cnt   = '0;
        cmd_data  = '0;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [3:0] cnt,
                          input logic [7:0] data,
                          output int nb, output int nd);
        issue(op, cnt, data);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            nb++;
            if (done) nd++;
            @(negedge clk);
        end
        if (busy) chk("busy_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_cnt   = '0;
        cmd_data  = '0;
        ser_in    = 1'b0;
`ifdef SHREG_CTRL_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ser_out", {31'd0, ser_out}, 32'd0);
        chk("rst_j", {24'd0, ff_j}, 32'hFF);
        chk("rst_k", {24'd0, ff_k}, 32'hFF);
        chk("rst_d", {24'd0, ff_d}, {24'd0, q});
        rst = 1'b0;
        @(negedge clk);

        // LOAD A5, inspect EXEC code
        issue(LOAD, 4'd0, 8'hA5);
        chk("load_busy", {31'd0, busy}, 32'd1);
        chk("load_d", {24'd0, ff_d}, 32'hA5);
        @(negedge clk);
        chk("load_done", {31'd0, done}, 32'd1);
        chk("load_q", {24'd0, q}, 32'hA5);
        @(negedge clk);
        chk("load_ready", {31'd0, cmd_ready}, 32'd1);

        // SHL 3 with ser_in=1
        ser_in = 1'b1;
        issue(SHL, 4'd3, 8'h00);
        chk("shl_so0", {31'd0, ser_out}, 32'd1);
        @(negedge clk);
        chk("shl_q1", {24'd0, q}, 32'h4B);
        chk("shl_so1", {31'd0, ser_out}, 32'd0);
        @(negedge clk);
        chk("shl_q2", {24'd0, q}, 32'h97);
        chk("shl_so2", {31'd0, ser_out}, 32'd1);
        chk("shl_nodone", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("shl_done", {31'd0, done}, 32'd1);
        chk("shl_q3", {24'd0, q}, 32'h2F);
        chk("shl_so_done", {31'd0, ser_out}, 32'd0);
        @(negedge clk);
        chk("shl_done_clr", {31'd0, done}, 32'd0);
        chk("shl_ready", {31'd0, cmd_ready}, 32'd1);

        // SHR cnt=0 goes straight to DONE
        issue(SHR, 4'd0, 8'h00);
        chk("shr0_done", {31'd0, done}, 32'd1);
        chk("shr0_q", {24'd0, q}, 32'h2F);
        @(negedge clk);
        chk("shr0_ready", {31'd0, cmd_ready}, 32'd1);
        chk("shr0_q2", {24'd0, q}, 32'h2F);

        // SHR 2 with ser_in=0 from 2F
        ser_in = 1'b0;
        do_cmd(SHR, 4'd2, 8'h00, bcyc, dcnt);
        chk("shr2_q", {24'd0, q}, 32'h0B);
        chk("shr2_busy", bcyc, 32'd3);

        // ROTL 9 from 81
        do_cmd(LOAD, 4'd0, 8'h81, bcyc, dcnt);
        chk("load81_busy", bcyc, 32'd2);
        do_cmd(ROTL, 4'd9, 8'h00, bcyc, dcnt);
        chk("rotl_q", {24'd0, q}, 32'h03);
        chk("rotl_busy", bcyc, 32'd10);
        chk("rotl_dcnt", dcnt, 32'd1);

        // Back-to-back INV/CLR/SET with cmd_valid held high
        do_cmd(LOAD, 4'd0, 8'h0F, bcyc, dcnt);
        cmd_valid = 1'b1;
        cmd_op    = INV;
        @(negedge clk);
        chk("inv_busy", {31'd0, busy}, 32'd1);
        chk("inv_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("inv_done", {31'd0, done}, 32'd1);
        chk("inv_q", {24'd0, q}, 32'hF0);
        cmd_op = CLR;
        @(negedge clk);
        chk("b2b_gap_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        chk("clr_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("clr_done", {31'd0, done}, 32'd1);
        chk("clr_q", {24'd0, q}, 32'h00);
        cmd_op = SET;
        @(negedge clk);
        @(negedge clk);
        chk("set_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("set_done", {31'd0, done}, 32'd1);
        chk("set_q", {24'd0, q}, 32'hFF);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        @(negedge clk);
        chk("set_ready", {31'd0, cmd_ready}, 32'd1);

        // NOP takes DONE only
        do_cmd(NOP, 4'd0, 8'h00, bcyc, dcnt);
        chk("nop_busy", bcyc, 32'd1);
        chk("nop_q", {24'd0, q}, 32'hFF);

        // Reset in the middle of SHL cnt=5
        do_cmd(LOAD, 4'd0, 8'h01, bcyc, dcnt);
        issue(SHL, 4'd5, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("mid_q", {24'd0, q}, 32'h04);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("mid_no_done", dcnt, 32'd0);
        chk("mid_q_kept", {24'd0, q}, 32'h04);

`ifdef SHREG_CTRL_ABORT_EN
        // Abort during the second EXEC cycle of SHL 6
        do_cmd(LOAD, 4'd0, 8'hFF, bcyc, dcnt);
        issue(SHL, 4'd6, 8'h00);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abt_done", {31'd0, done}, 32'd1);
        chk("abt_flag", {31'd0, aborted}, 32'd1);
        chk("abt_q", {24'd0, q}, 32'hFC);
        @(negedge clk);
        chk("abt_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abt_q2", {24'd0, q}, 32'hFC);
        do_cmd(NOP, 4'd0, 8'h00, bcyc, dcnt);
        chk("abt_cleared", {31'd0, aborted}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
